// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared formats, mapping and limits for the transmit polyphase shaper
package tx_pkg;

    localparam int OS       = 4;
    localparam int NBAUD    = 6;
    localparam int NUM_COEF = OS * NBAUD;

    localparam int NBT_COEF = 10;
    localparam int NBF_COEF = 7;

    // Worst case is NBAUD full-scale taps of either sign.
    localparam int NBT_ACC  = NBT_COEF + 1 + $clog2(NBAUD);
    localparam int NBF_ACC  = NBF_COEF;

    localparam int NBT_OUT  = 8;
    localparam int NBF_OUT  = 7;

    localparam int PH_W     = $clog2(OS);
    localparam int IDX_W    = $clog2(NUM_COEF);

    // QPSK mapping: this bit value means -1, the other means +1.
    localparam logic SYM_BIT_NEG = 1'b1;

    // Output saturation limits in S(NBT_OUT,NBF_OUT) integer units.
    localparam int SAT_MAX = (1 << (NBT_OUT - 1)) - 1;
    localparam int SAT_MIN = -(1 << (NBT_OUT - 1));

    // 1.0 in the coefficient format.
    localparam int COEF_ONE = 1 << NBF_COEF;

    // Idle coefficient bank: a delta at the filter centre.
    function automatic logic signed [NBT_COEF-1:0] coef_reset(input int j);
        return (j == NUM_COEF / 2) ? NBT_COEF'(COEF_ONE) : '0;
    endfunction

endpackage

// File: rtl/tx_polyphase_branch.sv
// rtl/tx_polyphase_branch.sv - one rail: symbol shifter, sign-select adder, saturation, output register
module tx_polyphase_branch
    import tx_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic                       en_i,
    input  logic                       shift_i,
    input  logic                       sym_i,
    input  logic [PH_W-1:0]            phase_i,
    input  logic signed [NBT_COEF-1:0] coef_i [NUM_COEF],
    output logic [NBT_OUT-1:0]         data_o
);

    localparam int FSHIFT = NBF_ACC - NBF_OUT;
    localparam logic signed [NBT_ACC-1:0] ACC_MAX = NBT_ACC'(SAT_MAX);
    localparam logic signed [NBT_ACC-1:0] ACC_MIN = NBT_ACC'(SAT_MIN);

    logic [NBAUD-1:0]          valid_q, valid_d;
    logic [NBAUD-1:0]          neg_q, neg_d;
    logic [NBT_OUT-1:0]        data_q, data_d;
    logic signed [NBT_ACC-1:0] acc;
    logic signed [NBT_ACC-1:0] aligned;

    // Shifter: empty while idle, shift a new symbol into slot 0 on capture.
    always_comb begin
        valid_d = valid_q;
        neg_d   = neg_q;
        if (!en_i) begin
            valid_d = '0;
        end else if (shift_i) begin
            valid_d = {valid_q[NBAUD-2:0], 1'b1};
            neg_d   = {neg_q[NBAUD-2:0], (sym_i == SYM_BIT_NEG)};
        end
    end

    // Polyphase sum: slot k uses tap phase + OS*k, added or subtracted by its sign.
    always_comb begin
        logic signed [NBT_COEF-1:0] c;
        logic signed [NBT_ACC-1:0]  tap;
        c   = '0;
        tap = '0;
        acc = '0;
        for (int k = 0; k < NBAUD; k++) begin
            c   = coef_i[IDX_W'(k * OS) + IDX_W'(phase_i)];
            tap = {{(NBT_ACC - NBT_COEF){c[NBT_COEF-1]}}, c};
            if (valid_q[k]) begin
                acc = neg_q[k] ? (acc - tap) : (acc + tap);
            end
        end
    end

    // Fraction alignment then clamp to the output range.
    always_comb begin
        aligned = acc >>> FSHIFT;
        data_d  = aligned[NBT_OUT-1:0];
        if (aligned > ACC_MAX) begin
            data_d = NBT_OUT'(SAT_MAX);
        end else if (aligned < ACC_MIN) begin
            data_d = NBT_OUT'(SAT_MIN);
        end
    end

    // State and output register; the output holds while idle.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            valid_q <= '0;
            neg_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            neg_q   <= neg_d;
            if (en_i) begin
                data_q <= data_d;
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/tx_polyphase_shaper.sv
// rtl/tx_polyphase_shaper.sv - I/Q polyphase pulse-shaping interpolator, one sample per clock
module tx_polyphase_shaper
    import tx_pkg::*;
(
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_en_tx,
    input  logic                         i_sym_I,
    input  logic                         i_sym_Q,
    input  logic [NUM_COEF*NBT_COEF-1:0] i_coeffs,
    input  logic                         i_load_coef,
    output logic                         o_sym_req,
    output logic [NBT_OUT-1:0]           o_data_I,
    output logic [NBT_OUT-1:0]           o_data_Q,
    output logic                         o_valid
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);

    logic [PH_W-1:0]            phase_q, phase_d;
    logic signed [NBT_COEF-1:0] coef_q  [NUM_COEF];
    logic signed [NBT_COEF-1:0] coef_d  [NUM_COEF];
    logic signed [NBT_COEF-1:0] coef_in [NUM_COEF];
    logic                       valid_q;

    // A symbol is taken on the edge that closes the last phase.
    assign o_sym_req = i_en_tx && (phase_q == PH_LAST);

    // Unpack the flat coefficient bus, h[j] in slice j.
    always_comb begin
        for (int j = 0; j < NUM_COEF; j++) begin
            coef_in[j] = i_coeffs[j*NBT_COEF +: NBT_COEF];
        end
    end

    // Phase counter and coefficient bank: idle parks both, otherwise count and load.
    always_comb begin
        phase_d = phase_q;
        coef_d  = coef_q;
        if (!i_en_tx) begin
            phase_d = PH_LAST;
            for (int j = 0; j < NUM_COEF; j++) begin
                coef_d[j] = coef_reset(j);
            end
        end else begin
            phase_d = o_sym_req ? '0 : (phase_q + PH_W'(1));
            if (i_load_coef) begin
                coef_d = coef_in;
            end
        end
    end

    // Shared control registers.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            phase_q <= PH_LAST;
            valid_q <= 1'b0;
            for (int j = 0; j < NUM_COEF; j++) begin
                coef_q[j] <= coef_reset(j);
            end
        end else begin
            phase_q <= phase_d;
            valid_q <= i_en_tx;
            coef_q  <= coef_d;
        end
    end

    assign o_valid = valid_q;

    tx_polyphase_branch u_branch_i (
        .clk     (clk),
        .reset_i (i_reset),
        .en_i    (i_en_tx),
        .shift_i (o_sym_req),
        .sym_i   (i_sym_I),
        .phase_i (phase_q),
        .coef_i  (coef_q),
        .data_o  (o_data_I)
    );

    tx_polyphase_branch u_branch_q (
        .clk     (clk),
        .reset_i (i_reset),
        .en_i    (i_en_tx),
        .shift_i (o_sym_req),
        .sym_i   (i_sym_Q),
        .phase_i (phase_q),
        .coef_i  (coef_q),
        .data_o  (o_data_Q)
    );

endmodule
